bus_loads_16bit: RTL

Receiving end of the 16-bit transfer path. Holds the six 16-bit architectural registers (PCRA0, PCRA1, SP, SI, DI, TX) and captures XferBus into any of them on active-low load strobes. Applies the auto increment/decrement the microcode requests for SP, SI and DI. Its register outputs feed the 16-bit bus assert muxes, so it closes the loop for the address and transfer buses.

---
 rtl/bus_loads_16bit_pkg.sv | 44 ++++
 rtl/bus_loads_16bit_reg16_incdec.sv | 55 +++++
 rtl/bus_loads_16bit.sv | 87 ++++++++
 3 files changed

// File: rtl/bus_loads_16bit_pkg.sv
// Shared definitions for the 16-bit transfer path: word width, reset value,
// strobe polarity and the load/inc/dec step decoding used by the
// auto-stepping registers.
package bus_loads_16bit_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  // Value every architectural register takes while rst_n is low.
  localparam word_t RESET_VAL = 16'h0000;

  // Step boundaries that define an SP wrap.
  localparam word_t WORD_MIN = 16'h0000;
  localparam word_t WORD_MAX = 16'hFFFF;

  // Microcode strobes are active low; shared with the bus assert muxes.
  localparam logic ASSERTED = 1'b0;

  // Resolved action for one auto-stepping register on the next edge.
  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_LOAD = 2'd1,
    STEP_INC  = 2'd2,
    STEP_DEC  = 2'd3
  } step_e;

  // Load beats Inc/Dec; Inc and Dec together cancel to a hold.
  function automatic step_e decode_step(input logic load_n,
                                        input logic inc_n,
                                        input logic dec_n);
    step_e step;
    step = STEP_HOLD;
    if (load_n == ASSERTED) begin
      step = STEP_LOAD;
    end else if ((inc_n == ASSERTED) && (dec_n != ASSERTED)) begin
      step = STEP_INC;
    end else if ((dec_n == ASSERTED) && (inc_n != ASSERTED)) begin
      step = STEP_DEC;
    end
    return step;
  endfunction

endpackage

// File: rtl/bus_loads_16bit_reg16_incdec.sv
// One 16-bit register with active-low load, increment and decrement.
// Load has priority; Inc+Dec together hold. The wrap output is a registered
// one-cycle pulse after the register stepped FFFF->0000 or 0000->FFFF.
module reg16_incdec
  import bus_loads_16bit_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  word_t d,
  input  logic  load_n,
  input  logic  inc_n,
  input  logic  dec_n,
  output word_t q,
  output logic  wrap
);

  step_e step;
  word_t q_next;
  logic  wrap_next;

  // Resolve the next register value and whether this step wraps.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    step      = decode_step(load_n, inc_n, dec_n);
    q_next    = q;
    wrap_next = 1'b0;
    case (step)
      STEP_LOAD: q_next = d;
      STEP_INC: begin
        q_next    = q + word_t'(1);
        wrap_next = (q == WORD_MAX);
      end
      STEP_DEC: begin
        q_next    = q - word_t'(1);
        wrap_next = (q == WORD_MIN);
      end
      default: ;
    endcase
  end

  // Register the value and the wrap pulse; reset clears both at once.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      q    <= RESET_VAL;
      wrap <= 1'b0;
    end else begin
      q    <= q_next;
      wrap <= wrap_next;
    end
  end

endmodule

// File: rtl/bus_loads_16bit.sv
// Receiving end of the 16-bit transfer path. Holds PCRA0, PCRA1, SP, SI, DI
// and TX, captures XferBus on active-low load strobes, and applies the
// microcode-requested auto increment/decrement to SP, SI and DI. Outputs are
// register Q only, so nothing combinational reaches the bus assert muxes.
module bus_loads_16bit
  import bus_loads_16bit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] XferBus,
  input  logic              PCRA0_Reg_Load,
  input  logic              PCRA1_Reg_Load,
  input  logic              SP_Reg_Load,
  input  logic              SI_Reg_Load,
  input  logic              DI_Reg_Load,
  input  logic              TX_Reg_Load,
  input  logic              SP_Reg_Inc,
  input  logic              SP_Reg_Dec,
  input  logic              SI_Reg_Inc,
  input  logic              DI_Reg_Inc,
  input  logic              SI_Reg_Dec,
  input  logic              DI_Reg_Dec,
  output logic [WORD_W-1:0] PCRA0_Reg,
  output logic [WORD_W-1:0] PCRA1_Reg,
  output logic [WORD_W-1:0] SP_Reg,
  output logic [WORD_W-1:0] SI_Reg,
  output logic [WORD_W-1:0] DI_Reg,
  output logic [WORD_W-1:0] TX_Reg,
  output logic              SP_Wrap
);

  // Only SP reports wraps; the index registers' wrap pulses go nowhere.
  logic si_wrap_unused;
  logic di_wrap_unused;

  // Stack pointer: load/inc/dec with wrap reporting.
  reg16_incdec u_sp (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (XferBus),
    .load_n (SP_Reg_Load),
    .inc_n  (SP_Reg_Inc),
    .dec_n  (SP_Reg_Dec),
    .q      (SP_Reg),
    .wrap   (SP_Wrap)
  );

  // Source index.
  reg16_incdec u_si (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (XferBus),
    .load_n (SI_Reg_Load),
    .inc_n  (SI_Reg_Inc),
    .dec_n  (SI_Reg_Dec),
    .q      (SI_Reg),
    .wrap   (si_wrap_unused)
  );

  // Destination index.
  reg16_incdec u_di (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (XferBus),
    .load_n (DI_Reg_Load),
    .inc_n  (DI_Reg_Inc),
    .dec_n  (DI_Reg_Dec),
    .q      (DI_Reg),
    .wrap   (di_wrap_unused)
  );

  // Plain load-enable registers: PCRA0, PCRA1 and TX change only on Load.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these are architectural registers, not storage arrays, so each
    // one gets an explicit reset value software can rely on.
    if (!rst_n) begin
      PCRA0_Reg <= RESET_VAL;
      PCRA1_Reg <= RESET_VAL;
      TX_Reg    <= RESET_VAL;
    end else begin
      if (PCRA0_Reg_Load == ASSERTED) PCRA0_Reg <= XferBus;
      if (PCRA1_Reg_Load == ASSERTED) PCRA1_Reg <= XferBus;
      if (TX_Reg_Load == ASSERTED)    TX_Reg    <= XferBus;
    end
  end

endmodule
